// File: rtl/switch_mcu_regfile.sv
// ---------------------------------------------------------------------------
// switch_mcu_regfile
//   Integer register file x0..x31 for the switch core ALU op units.
//
//   Ports
//     in_clk, in_rst           clock, asynchronous active-low reset
//     in_ren_n / in_raddr_n    read request, port n (n = 1, 2)
//     out_rdata_n              registered read data, valid the cycle after ren
//     in_wen / in_waddr /      single write port
//     in_wdata
//     in_dbg_raddr /           combinational debug read (no bypass)
//     out_dbg_rdata
//     out_wr_cnt               committed (nonzero-address) write count, wraps
//     out_x0_wr                one-cycle pulse after a write aimed at x0
//
//   Read protocol: the requester drives in_ren_n/in_raddr_n in cycle T and
//   samples out_rdata_n in cycle T+1; there is no back-pressure, so every
//   enabled request is served. Without ren, out_rdata_n holds its value.
//
//   NUM_REGS must equal 2**ADDR_W.
// ---------------------------------------------------------------------------
module switch_mcu_regfile #(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        ADDR_W   = 5,
  parameter int unsigned        NUM_REGS = 32,
  parameter logic [DATA_W-1:0]  SP_INIT  = 32'h0000_0000,
  parameter int unsigned        CNT_W    = 16
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_ren_1,
  input  logic [ADDR_W-1:0] in_raddr_1,
  output logic [DATA_W-1:0] out_rdata_1,
  input  logic              in_ren_2,
  input  logic [ADDR_W-1:0] in_raddr_2,
  output logic [DATA_W-1:0] out_rdata_2,
  input  logic              in_wen,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [ADDR_W-1:0] in_dbg_raddr,
  output logic [DATA_W-1:0] out_dbg_rdata,
  output logic [CNT_W-1:0]  out_wr_cnt,
  output logic              out_x0_wr
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] rdata_1_q, rdata_1_d;
  logic [DATA_W-1:0] rdata_2_q, rdata_2_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              x0_wr_q, x0_wr_d;
  logic              wr_commit;

  // Writes to x0 are dropped; only nonzero targets change state.
  assign wr_commit = in_wen && (in_waddr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_commit) begin
      regs_d[in_waddr] = in_wdata;
    end
  end

  // Read ports: x0 reads as zero; a same-edge write to the read address
  // is forwarded so the requester never sees the stale value.
  always_comb begin
    rdata_1_d = rdata_1_q;
    if (in_ren_1) begin
      if (in_raddr_1 == '0) begin
        rdata_1_d = '0;
      end else if (wr_commit && (in_waddr == in_raddr_1)) begin
        rdata_1_d = in_wdata;
      end else begin
        rdata_1_d = regs_q[in_raddr_1];
      end
    end
  end

  always_comb begin
    rdata_2_d = rdata_2_q;
    if (in_ren_2) begin
      if (in_raddr_2 == '0) begin
        rdata_2_d = '0;
      end else if (wr_commit && (in_waddr == in_raddr_2)) begin
        rdata_2_d = in_wdata;
      end else begin
        rdata_2_d = regs_q[in_raddr_2];
      end
    end
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (wr_commit) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
    x0_wr_d = in_wen && (in_waddr == '0);
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= (i == 2) ? SP_INIT : '0;
      end
      rdata_1_q <= '0;
      rdata_2_q <= '0;
      wr_cnt_q  <= '0;
      x0_wr_q   <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      rdata_1_q <= rdata_1_d;
      rdata_2_q <= rdata_2_d;
      wr_cnt_q  <= wr_cnt_d;
      x0_wr_q   <= x0_wr_d;
    end
  end

  assign out_rdata_1   = rdata_1_q;
  assign out_rdata_2   = rdata_2_q;
  assign out_wr_cnt    = wr_cnt_q;
  assign out_x0_wr     = x0_wr_q;
  assign out_dbg_rdata = (in_dbg_raddr == '0) ? '0 : regs_q[in_dbg_raddr];

endmodule

// File: tb/tb_switch_mcu_regfile.sv
module tb_switch_mcu_regfile;

  localparam logic [31:0] SP = 32'h1000_FFF0;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        ren_1 = 0, ren_2 = 0, wen = 0;
  logic [4:0]  raddr_1 = 0, raddr_2 = 0, waddr = 0, dbg_raddr = 0;
  logic [31:0] wdata = 0;
  logic [31:0] rdata_1, rdata_2, dbg_rdata;
  logic [15:0] wr_cnt;
  logic        x0_wr;

  switch_mcu_regfile #(
    .DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .SP_INIT(SP), .CNT_W(16)
  ) dut (
    .in_clk(clk), .in_rst(rst),
    .in_ren_1(ren_1), .in_raddr_1(raddr_1), .out_rdata_1(rdata_1),
    .in_ren_2(ren_2), .in_raddr_2(raddr_2), .out_rdata_2(rdata_2),
    .in_wen(wen), .in_waddr(waddr), .in_wdata(wdata),
    .in_dbg_raddr(dbg_raddr), .out_dbg_rdata(dbg_rdata),
    .out_wr_cnt(wr_cnt), .out_x0_wr(x0_wr)
  );

  // ---------------- reference model ----------------
  // Architectural view: a write lands in the array, and a read issued at the
  // same edge observes the array as it stands after that edge.
  logic [31:0] m_mem [32];
  logic [31:0] m_r1, m_r2;
  int unsigned m_cnt;
  logic        m_x0;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    m_mem[2] = SP;
    m_r1 = 0; m_r2 = 0; m_cnt = 0; m_x0 = 0;
  endtask

  task automatic model_step();
    m_x0 = wen && (waddr == 0);
    if (wen && waddr != 0) begin
      m_mem[waddr] = wdata;
      m_cnt = (m_cnt + 1) % 65536;
    end
    if (ren_1) m_r1 = m_mem[raddr_1];
    if (ren_2) m_r2 = m_mem[raddr_2];
  endtask

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r1, input logic [4:0] a1,
                       input logic r2, input logic [4:0] a2, input logic [4:0] da);
    @(negedge clk);
    wen = w; waddr = wa; wdata = wd;
    ren_1 = r1; raddr_1 = a1; ren_2 = r2; raddr_2 = a2; dbg_raddr = da;
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic w; logic [4:0] wa; logic [31:0] wd;
    logic r1; logic [4:0] a1; logic r2; logic [4:0] a2; logic [4:0] da;
    logic [31:0] e_r1; logic [31:0] e_r2; logic [31:0] e_dbg;
    logic [15:0] e_cnt; logic e_x0;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(logic w, logic [4:0] wa, logic [31:0] wd,
                              logic r1, logic [4:0] a1, logic r2, logic [4:0] a2,
                              logic [4:0] da, logic [31:0] e1, logic [31:0] e2,
                              logic [31:0] ed, logic [15:0] ec, logic ex);
    vec_t v;
    v.w = w; v.wa = wa; v.wd = wd; v.r1 = r1; v.a1 = a1; v.r2 = r2; v.a2 = a2;
    v.da = da; v.e_r1 = e1; v.e_r2 = e2; v.e_dbg = ed; v.e_cnt = ec; v.e_x0 = ex;
    return v;
  endfunction

  localparam logic [31:0] W1 = 32'hA5A5_0001;

  initial begin
    //               w  wa wdata          r1 a1 r2 a2 da  e_r1          e_r2          e_dbg         cnt x0
    vecs[0] = mk(0, 0, 32'h0,          1, 2, 1, 5, 2,  SP,           32'h0,        SP,           0, 0);
    vecs[1] = mk(1, 5, 32'hDEAD_BEEF,  0, 0, 0, 0, 5,  SP,           32'h0,        32'hDEAD_BEEF, 1, 0);
    vecs[2] = mk(0, 0, 32'h0,          1, 5, 0, 0, 7,  32'hDEAD_BEEF, 32'h0,       32'h0,        1, 0);
    vecs[3] = mk(1, 7, 32'h1234_5678,  0, 0, 1, 7, 7,  32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678, 2, 0);
    vecs[4] = mk(1, 0, 32'hFFFF_FFFF,  0, 0, 0, 0, 0,  32'hDEAD_BEEF, 32'h1234_5678, 32'h0,       2, 1);
    vecs[5] = mk(0, 0, 32'h0,          1, 0, 1, 0, 0,  32'h0,        32'h0,        32'h0,        2, 0);
    vecs[6] = mk(0, 0, 32'h0,          1, 5, 0, 0, 5,  32'hDEAD_BEEF, 32'h0,       32'hDEAD_BEEF, 2, 0);
    vecs[7] = mk(1, 5, 32'h0000_0001,  0, 5, 0, 0, 5,  32'hDEAD_BEEF, 32'h0,       32'h0000_0001, 3, 0);
    vecs[8] = mk(0, 0, 32'h0,          1, 5, 1, 5, 2,  32'h0000_0001, 32'h0000_0001, SP,          3, 0);

    // reset state while held
    model_reset();
    #12;
    chk("rst_rdata_1", rdata_1, 32'h0);
    chk("rst_rdata_2", rdata_2, 32'h0);
    chk("rst_wr_cnt", {16'h0, wr_cnt}, 32'h0);
    chk("rst_x0_wr", {31'h0, x0_wr}, 32'h0);
    dbg_raddr = 2; #1;
    chk("rst_dbg_x2", dbg_rdata, SP);
    @(negedge clk);
    rst = 1'b1;

    // directed table
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].w, vecs[i].wa, vecs[i].wd, vecs[i].r1, vecs[i].a1,
            vecs[i].r2, vecs[i].a2, vecs[i].da);
      chk($sformatf("vec%0d_rdata_1", i), rdata_1, vecs[i].e_r1);
      chk($sformatf("vec%0d_rdata_2", i), rdata_2, vecs[i].e_r2);
      chk($sformatf("vec%0d_dbg", i), dbg_rdata, vecs[i].e_dbg);
      chk($sformatf("vec%0d_wr_cnt", i), {16'h0, wr_cnt}, {16'h0, vecs[i].e_cnt});
      chk($sformatf("vec%0d_x0_wr", i), {31'h0, x0_wr}, {31'h0, vecs[i].e_x0});
    end

    // randomized against the model; narrow address range most of the time
    // so bypass and same-address cases occur often
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa, a1, a2, da;
      int unsigned hi;
      hi = ($urandom_range(0, 3) == 0) ? 31 : 4;
      wa = 5'($urandom_range(0, hi)); a1 = 5'($urandom_range(0, hi));
      a2 = 5'($urandom_range(0, hi)); da = 5'($urandom_range(0, hi));
      cycle(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)), a1,
            1'($urandom_range(0, 1)), a2, da);
      exp_q.push_back(m_r1);
      chk("rnd_rdata_1", rdata_1, exp_q.pop_front());
      chk("rnd_rdata_2", rdata_2, m_r2);
      chk("rnd_dbg", dbg_rdata, m_mem[dbg_raddr]);
      chk("rnd_wr_cnt", {16'h0, wr_cnt}, m_cnt);
      chk("rnd_x0_wr", {31'h0, x0_wr}, {31'h0, m_x0});
    end

    // counter wrap: write x1 until the count comes round to zero
    begin
      int n;
      n = 65536 - int'(m_cnt);
      for (int i = 0; i < n - 1; i++) cycle(1, 1, W1, 0, 0, 0, 0, 1);
      chk("wrap_cnt_max", {16'h0, wr_cnt}, 32'h0000_FFFF);
      cycle(1, 1, W1, 0, 0, 0, 0, 1);
      chk("wrap_cnt_zero", {16'h0, wr_cnt}, 32'h0);
      chk("wrap_model_cnt", m_cnt, 32'h0);
    end

    // put nonzero values on the outputs, then reset mid-stream
    cycle(0, 0, 0, 1, 1, 1, 1, 1);
    chk("pre_rst_rdata_1", rdata_1, W1);
    cycle(1, 3, 32'h0000_0055, 0, 0, 0, 0, 3);
    chk("pre_rst_cnt", {16'h0, wr_cnt}, 32'h1);
    @(negedge clk);
    ren_1 = 1; raddr_1 = 1; wen = 1; waddr = 4; wdata = 32'hCAFE_0004; dbg_raddr = 2;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_rdata_1", rdata_1, 32'h0);
    chk("mid_rst_rdata_2", rdata_2, 32'h0);
    chk("mid_rst_cnt", {16'h0, wr_cnt}, 32'h0);
    chk("mid_rst_x0", {31'h0, x0_wr}, 32'h0);
    chk("mid_rst_dbg_x2", dbg_rdata, SP);
    dbg_raddr = 3; #1;
    chk("mid_rst_dbg_x3", dbg_rdata, 32'h0);
    @(posedge clk); #1;
    dbg_raddr = 4; #1;
    chk("in_rst_dbg_x4", dbg_rdata, 32'h0);
    chk("in_rst_rdata_1", rdata_1, 32'h0);
    chk("in_rst_cnt", {16'h0, wr_cnt}, 32'h0);
    @(negedge clk);
    wen = 0; ren_1 = 0;
    rst = 1'b1;
    model_reset();
    cycle(0, 0, 0, 1, 2, 1, 1, 1);
    chk("post_rst_rdata_1", rdata_1, SP);
    chk("post_rst_rdata_2", rdata_2, 32'h0);
    chk("post_rst_dbg_x1", dbg_rdata, 32'h0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/switch_mcu_regfile.md
Name: switch_mcu_regfile

Overview:
- Integer register file (x0..x31) serving the ALU op units of the switch core.
- Responder side of the op units' register read/write port protocol:
  - op units drive read enables and addresses, then sample read data one cycle later;
  - op units write results through a single write port.
- Provides two registered read ports, one write port with write-to-read bypass, a combinational debug read port, and a commit counter.

Parameters:
- DATA_W, 32: register and data width.
- ADDR_W, 5: register address width.
- NUM_REGS, 32: number of architectural registers; must equal 2**ADDR_W.
- SP_INIT, 32'h0000_0000: reset value of x2 (stack pointer).
- CNT_W, 16: width of the write-commit counter.

Ports:
- in_clk, input, 1: clock.
- in_rst, input, 1: reset, asynchronous, active-low.
- in_ren_1, input, 1: read enable, port 1.
- in_raddr_1, input, ADDR_W: read address, port 1.
- out_rdata_1, output, DATA_W: registered read data, port 1.
- in_ren_2, input, 1: read enable, port 2.
- in_raddr_2, input, ADDR_W: read address, port 2.
- out_rdata_2, output, DATA_W: registered read data, port 2.
- in_wen, input, 1: write enable.
- in_waddr, input, ADDR_W: write address.
- in_wdata, input, DATA_W: write data.
- in_dbg_raddr, input, ADDR_W: debug read address.
- out_dbg_rdata, output, DATA_W: combinational debug read data.
- out_wr_cnt, output, CNT_W: count of committed writes.
- out_x0_wr, output, 1: one-cycle pulse when a write targets x0.

Behaviour:
- Reset is in_rst, asynchronous, active-low; clock is in_clk. Reset values:
  - x2 = SP_INIT; all other registers = 0.
  - out_rdata_1 = 0, out_rdata_2 = 0.
  - out_wr_cnt = 0, out_x0_wr = 0.
- Reset asserted mid-operation: all of the above clear immediately, and any in-flight read or write is discarded.
- Read ports (identical, independent):
  - At a posedge with in_ren_n = 1, out_rdata_n takes the value of register in_raddr_n.
  - Latency: data is valid in the cycle after the enable cycle. The requester drives ren in cycle T and samples rdata in cycle T+1.
  - With in_ren_n = 0, out_rdata_n holds its previous value.
  - in_raddr_n = 0 always returns 0.
- Bypass: if in_ren_n = 1, in_wen = 1, in_waddr = in_raddr_n and the address is nonzero at the same edge, out_rdata_n takes in_wdata, not the stale register value.
- Both ports may read the same address in the same cycle; both return the same value.
- Write:
  - At a posedge with in_wen = 1 and in_waddr != 0, register in_waddr takes in_wdata.
  - The write is visible to ordinary reads enabled from the next cycle on.
  - in_waddr = 0: no state changes and out_x0_wr pulses high for exactly one cycle. Otherwise out_x0_wr = 0.
- Commit counter:
  - out_wr_cnt increments by 1 on each write to a nonzero address.
  - It wraps from 2**CNT_W-1 to 0.
  - x0 writes do not count.
- Debug port:
  - out_dbg_rdata = register in_dbg_raddr, combinational, with no bypass.
  - Address 0 returns 0.
  - A write becomes visible on this port after the write edge.
- No state machine is required beyond the register array, the read registers, the counter and the pulse flop. All signals are sampled only at the in_clk posedge.

Test Plan:
- Reset release, then read x2 and x5 on ports 1 and 2 -> out_rdata_1 = SP_INIT and out_rdata_2 = 0 one cycle after ren; out_wr_cnt = 0.
- Write x5 = 32'hDEAD_BEEF; next cycle ren_1 with raddr_1 = 5 -> out_rdata_1 = 32'hDEAD_BEEF on the following cycle; out_wr_cnt = 1; dbg_raddr = 5 shows the value right after the write edge.
- Same-edge write x7 = 32'h1234_5678 and ren_2 with raddr_2 = 7, where x7 previously held 0 -> out_rdata_2 = 32'h1234_5678 (bypass).
- Write x0 = 32'hFFFF_FFFF -> out_x0_wr pulses for one cycle; a subsequent read of x0 returns 0; out_wr_cnt unchanged.
- ren_1 pulses once with raddr_1 = 5, then ren_1 = 0 while x5 is rewritten to 32'h0000_0001 -> out_rdata_1 holds 32'hDEAD_BEEF.
- Preload the counter near wrap via 65536 writes to x1 -> out_wr_cnt returns to 0. Then assert in_rst mid-stream with ren_1 = 1 -> all outputs 0 immediately and x2 = SP_INIT.
